// File: rtl/booth_r4_seq_accumulator.sv
// Sequential radix-4 Booth multiplier: one partial product per RUN cycle, accumulated into a 64-bit result.
// Latency: out_valid T+17 (signed) / T+18 (unsigned) after accept; variable (min T+2) with BOOTH_R4_EARLY_TERM_EN.
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module booth_r4_seq_accumulator (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  input  logic        sign,
  output logic [31:0] pp_multiplicand,
  output logic [2:0]  pp_booth,
  output logic        pp_sign,
  input  logic [33:0] pp,
  output logic [63:0] product,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] x_q, x_d;
  // Multiplier pre-extended to 34 bits so the unsigned 17th group sees zeros above bit 31.
  logic [33:0] y_q, y_d;
  logic        sign_q, sign_d;
  logic [4:0]  idx_q, idx_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] product_q, product_d;

  logic [5:0]  sh;
  logic [2:0]  win;
  logic [4:0]  last_grp;
  logic        early;
  logic        done_now;
  logic [63:0] addend;

`ifdef BOOTH_R4_EARLY_TERM_EN
  logic signed [33:0] rem;
`endif

  // Booth window selection, early-termination test and next-state logic.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    sign_d    = sign_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    product_d = product_q;

    sh       = {idx_q, 1'b0};
    // Window i is {Y[2i+1], Y[2i], Y[2i-1]}; the appended zero supplies Y[-1].
    win      = 3'({y_q, 1'b0} >> sh);
    last_grp = sign_q ? 5'd15 : 5'd16;

`ifdef BOOTH_R4_EARLY_TERM_EN
    // Remaining windows are all 000/111 exactly when Y[33:2i+1] is all zeros or all ones.
    rem   = $signed(y_q) >>> (sh + 6'd1);
    early = (rem == '0) || (&rem);
`else
    early = 1'b0;
`endif
    done_now = (idx_q == last_grp) || early;

    // The generator negates by ones' complement; the missing +1 is injected at the same weight.
    addend = ({{30{pp[33]}}, pp} << sh) + (64'(win[2]) << sh);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = multiplicand;
          y_d     = sign ? {{2{multiplier[31]}}, multiplier} : {2'b00, multiplier};
          sign_d  = sign;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_q + addend;
        idx_d = idx_q + 5'd1;
        if (done_now) begin
          product_d = acc_q + addend;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      sign_q    <= 1'b0;
      idx_q     <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sign_q    <= sign_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign in_ready        = (state_q == S_IDLE);
  assign out_valid       = (state_q == S_DONE);
  assign product         = product_q;
  assign pp_multiplicand = x_q;
  assign pp_sign         = sign_q;
  assign pp_booth        = (state_q == S_RUN) ? win : 3'b000;

endmodule

// File: tb/tb_booth_r4_seq_accumulator.sv
// Bench for booth_r4_seq_accumulator: directed vector table, reset/hold sequences, random ops vs. arithmetic model.
module tb_booth_r4_seq_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        sign;
  logic [31:0] pp_multiplicand;
  logic [2:0]  pp_booth;
  logic        pp_sign;
  logic [33:0] pp;
  logic [63:0] product;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_r4_seq_accumulator dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(multiplicand), .multiplier(multiplier), .sign(sign),
    .pp_multiplicand(pp_multiplicand), .pp_booth(pp_booth), .pp_sign(pp_sign),
    .pp(pp),
    .product(product), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Partial-product generator: 0, +-X, +-2X selected by the window; negation as ones' complement.
  logic [33:0] gen_xe, gen_mag;
  always_comb begin
    gen_xe = pp_sign ? {{2{pp_multiplicand[31]}}, pp_multiplicand} : {2'b00, pp_multiplicand};
    case (pp_booth)
      3'b001, 3'b010, 3'b101, 3'b110: gen_mag = gen_xe;
      3'b011, 3'b100:                 gen_mag = gen_xe << 1;
      default:                        gen_mag = '0;
    endcase
    pp = pp_booth[2] ? ~gen_mag : gen_mag;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] a, b;
    a = s ? {{32{x[31]}}, x} : {32'b0, x};
    b = s ? {{32{y[31]}}, y} : {32'b0, y};
    return a * b;
  endfunction

  // Cycles from acceptance to out_valid.
  function automatic int lat_of(input logic [31:0] y, input logic s);
    int n;
    n = s ? 16 : 17;
`ifdef BOOTH_R4_EARLY_TERM_EN
    begin
      logic [34:0] yy;
      logic [2:0]  w;
      int          last;
      yy   = s ? {{2{y[31]}}, y, 1'b0} : {2'b00, y, 1'b0};
      last = 0;
      for (int g = 0; g < n; g++) begin
        w = yy[2*g+2 -: 3];
        if (w != 3'b000 && w != 3'b111) last = g;
      end
      return last + 2;
    end
`else
    return n + 1;
`endif
  endfunction

  // One full operation: accept, run (with noisy inputs), optional DONE hold, handshake.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [63:0] exp, input int hold, input string tag);
    int   lat;
    logic rdy_low;
    check({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; multiplicand = x; multiplier = y; sign = s; out_ready = 1'b0;
    tick();
    lat = 1;
    check({tag, " pp_operands"}, {31'b0, pp_sign, pp_multiplicand}, {31'b0, s, x});
    rdy_low = 1'b1;
    while (!out_valid && lat < 60) begin
      if (in_ready) rdy_low = 1'b0;
      in_valid = 1'($urandom); multiplicand = $urandom; multiplier = $urandom; sign = 1'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(lat_of(y, s)));
    check({tag, " in_ready_run"}, 64'(rdy_low), 64'd1);
    check({tag, " product"}, product, exp);
    check({tag, " done_pp_booth"}, 64'(pp_booth), 64'd0);
    for (int k = 0; k < hold; k++) begin
      check({tag, " hold_vld"}, {62'b0, out_valid, in_ready}, 64'd2);
      check({tag, " hold_prod"}, product, exp);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " after_hs"}, {62'b0, out_valid, in_ready}, 64'd1);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          seen;
    logic [31:0] rx, ry;
    logic        rs;

    vecs[0] = '{32'd3,         32'd5,         1'b1, 64'd15};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 64'd1};
    vecs[2] = '{32'h80000000,  32'h80000000,  1'b1, 64'h4000000000000000};
    vecs[3] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 64'hFFFFFFFE00000001};
    vecs[4] = '{32'd7,         32'd1,         1'b0, 64'd7};
    vecs[5] = '{32'hFFFFFFFD,  32'd5,         1'b1, 64'hFFFFFFFFFFFFFFF1};
    vecs[6] = '{32'h80000000,  32'd2,         1'b0, 64'h0000000100000000};
    vecs[7] = '{32'h12345678,  32'd0,         1'b1, 64'd0};

    rst = 1'b1; in_valid = 1'b0; multiplicand = '0; multiplier = '0; sign = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("reset_flags", {62'b0, in_ready, out_valid}, 64'd2);
    check("reset_product", product, 64'd0);
    check("reset_pp", {28'b0, pp_booth, pp_sign, pp_multiplicand}, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].p, 0, $sformatf("vec%0d", i));
      tick();
    end

    // DONE held with out_ready low for five cycles, released on the sixth.
    run_op(32'd1234, 32'hFFFF0000, 1'b1, ref_mul(32'd1234, 32'hFFFF0000, 1'b1), 5, "hold");

    // Reset in RUN group 7, then a clean unsigned 2*3.
    in_valid = 1'b1; multiplicand = 32'hFFFFFFFF; multiplier = 32'hFFFFFFFF; sign = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_flags", {59'b0, pp_booth, in_ready, out_valid}, 64'd2);
    check("abort_product", product, 64'd0);
    seen = 0;
    repeat (20) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort_no_stale", 64'(seen), 64'd0);
    run_op(32'd2, 32'd3, 1'b0, 64'd6, 0, "post_abort");

    // Reset dominates a simultaneous in_valid.
    rst = 1'b1; in_valid = 1'b1; multiplicand = 32'd9; multiplier = 32'd9; sign = 1'b0;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (20) begin
      if (out_valid || !in_ready) seen++;
      tick();
    end
    check("rst_dominates_in_valid", 64'(seen), 64'd0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom);
      rx = $urandom;
      case ($urandom_range(0, 3))
        0:       ry = $urandom_range(0, 255);
        1:       ry = -$urandom_range(1, 255);
        default: ry = $urandom;
      endcase
      run_op(rx, ry, rs, ref_mul(rx, ry, rs), $urandom_range(0, 2), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
